// File: rtl/fetch_sequencer_if.sv
// -----------------------------------------------------------------------------
// fetch_sequencer_if
// Bundles the instruction-fetch controller's hazard, redirect, memory and
// IF/ID signals. Names are prefixed from the sequencer's point of view:
//   i_stall            hazard unit: hold PC and IF/ID
//   i_branch_taken     resolved taken branch
//   i_branch_target    branch destination
//   i_jump_taken       jump / jr redirect
//   i_jump_target      jump destination
//   i_instruction      word returned by instruction memory for o_pc_result
//   o_pc_result        current fetch address
//   o_if_id_instruction, o_if_id_pc_plus4, o_if_id_valid   IF/ID register
//   o_halted           high while fetch is halted
//   o_fetch_count      number of valid instructions delivered
// Modports: master = fetch sequencer, slave = surrounding datapath / memory.
// -----------------------------------------------------------------------------
interface fetch_sequencer_if;
    logic        i_stall;
    logic        i_branch_taken;
    logic [31:0] i_branch_target;
    logic        i_jump_taken;
    logic [31:0] i_jump_target;
    logic [31:0] i_instruction;
    logic [31:0] o_pc_result;
    logic [31:0] o_if_id_instruction;
    logic [31:0] o_if_id_pc_plus4;
    logic        o_if_id_valid;
    logic        o_halted;
    logic [31:0] o_fetch_count;

    modport master (
        input  i_stall, i_branch_taken, i_branch_target,
               i_jump_taken, i_jump_target, i_instruction,
        output o_pc_result, o_if_id_instruction, o_if_id_pc_plus4,
               o_if_id_valid, o_halted, o_fetch_count
    );

    modport slave (
        output i_stall, i_branch_taken, i_branch_target,
               i_jump_taken, i_jump_target, i_instruction,
        input  o_pc_result, o_if_id_instruction, o_if_id_pc_plus4,
               o_if_id_valid, o_halted, o_fetch_count
    );
endinterface

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
// Instruction-fetch controller for the pipelined MIPS datapath. Owns the PC,
// presents it to a combinational instruction memory and captures the returned
// word into the IF/ID register. Handles hazard stalls, jump/branch redirects
// (one bubble) and a halt word that stops fetch until a redirect arrives.
// Ports:
//   i_clk    rising-edge clock
//   i_rst_n  asynchronous active-low reset
//   bus      fetch_sequencer_if.master (see interface header)
// Parameters:
//   RESET_PC   PC loaded at reset (bits [1:0] must be 0)
//   HALT_WORD  instruction encoding that stops fetch
// -----------------------------------------------------------------------------
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    fetch_sequencer_if.master  bus
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [31:0] r_pc;
    logic [31:0] r_if_id_instruction;
    logic [31:0] r_if_id_pc_plus4;
    logic        r_if_id_valid;
    logic        r_halted;
    logic [31:0] r_fetch_count;

    logic [31:0] w_pc_next;
    logic [31:0] w_if_id_instruction_next;
    logic [31:0] w_if_id_pc_plus4_next;
    logic        w_if_id_valid_next;
    logic        w_halted_next;
    logic [31:0] w_fetch_count_next;

    logic [31:0] w_pc_plus4;
    logic        w_redirect;
    logic [31:0] w_redirect_pc;
    logic        w_is_halt_word;

    assign w_pc_plus4     = r_pc + 32'd4;   // 32-bit modulo: 0xFFFF_FFFC wraps to 0
    assign w_redirect     = bus.i_jump_taken | bus.i_branch_taken;
    // Jump outranks branch; target word alignment is forced by masking.
    assign w_redirect_pc  = bus.i_jump_taken ? (bus.i_jump_target   & ~32'd3)
                                             : (bus.i_branch_target & ~32'd3);
    assign w_is_halt_word = (bus.i_instruction == HALT_WORD);

    // ------------------------------------------------------------------ state
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; combinational blocks use blocking (=).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------- next state
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would infer a latch.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_BOOT: w_state_next = ST_RUN;
            ST_RUN: begin
                // Redirects and stalls keep us running; only an un-stalled,
                // un-redirected halt word stops fetch.
                if (!w_redirect && !bus.i_stall && w_is_halt_word) begin
                    w_state_next = ST_HALT;
                end
            end
            ST_HALT: begin
                if (w_redirect) begin
                    w_state_next = ST_RUN;
                end
            end
            default: w_state_next = ST_BOOT;
        endcase
    end

    // ---------------------------------------------------------------- outputs
    always_comb begin
        w_pc_next                = r_pc;
        w_if_id_instruction_next = r_if_id_instruction;
        w_if_id_pc_plus4_next    = r_if_id_pc_plus4;
        w_if_id_valid_next       = r_if_id_valid;
        w_fetch_count_next       = r_fetch_count;
        case (r_state)
            ST_BOOT: begin
                w_if_id_valid_next = 1'b0;
            end
            ST_RUN: begin
                if (w_redirect) begin
                    // Redirect beats Stall: the stalled instruction is squashed.
                    w_pc_next          = w_redirect_pc;
                    w_if_id_valid_next = 1'b0;
                end else if (bus.i_stall) begin
                    // Hold everything.
                end else if (w_is_halt_word) begin
                    w_if_id_valid_next = 1'b0;   // halt word is never forwarded
                end else begin
                    w_pc_next                = w_pc_plus4;
                    w_if_id_instruction_next = bus.i_instruction;
                    w_if_id_pc_plus4_next    = w_pc_plus4;
                    w_if_id_valid_next       = 1'b1;
                    w_fetch_count_next       = r_fetch_count + 32'd1;
                end
            end
            ST_HALT: begin
                w_if_id_valid_next = 1'b0;
                if (w_redirect) begin
                    w_pc_next = w_redirect_pc;
                end
            end
            default: begin
                w_if_id_valid_next = 1'b0;
            end
        endcase
        w_halted_next = (w_state_next == ST_HALT);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pc                <= RESET_PC;
            r_if_id_instruction <= 32'd0;
            r_if_id_pc_plus4    <= 32'd0;
            r_if_id_valid       <= 1'b0;
            r_halted            <= 1'b0;
            r_fetch_count       <= 32'd0;
        end else begin
            r_pc                <= w_pc_next;
            r_if_id_instruction <= w_if_id_instruction_next;
            r_if_id_pc_plus4    <= w_if_id_pc_plus4_next;
            r_if_id_valid       <= w_if_id_valid_next;
            r_halted            <= w_halted_next;
            r_fetch_count       <= w_fetch_count_next;
        end
    end

    assign bus.o_pc_result         = r_pc;
    assign bus.o_if_id_instruction = r_if_id_instruction;
    assign bus.o_if_id_pc_plus4    = r_if_id_pc_plus4;
    assign bus.o_if_id_valid       = r_if_id_valid;
    assign bus.o_halted            = r_halted;
    assign bus.o_fetch_count       = r_fetch_count;

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
// Directed bench for fetch_sequencer. A 64-word combinational memory holds
// word i = i*3. A second instance with RESET_PC = 0xFFFF_FFFC covers PC wrap.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

    logic clk;
    logic rst_n;
    logic wrst_n;

    int checks;
    int failures;

    logic [31:0] mem [64];

    fetch_sequencer_if bus ();
    fetch_sequencer_if wbus ();

    fetch_sequencer #(
        .RESET_PC  (32'h0000_0000),
        .HALT_WORD (32'hFFFF_FFFF)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.master)
    );

    fetch_sequencer #(
        .RESET_PC  (32'hFFFF_FFFC),
        .HALT_WORD (32'hFFFF_FFFF)
    ) dut_wrap (
        .i_clk   (clk),
        .i_rst_n (wrst_n),
        .bus     (wbus.master)
    );

    assign bus.i_instruction  = mem[bus.o_pc_result[7:2]];
    assign wbus.i_instruction = mem[wbus.o_pc_result[7:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.i_stall         = 1'b0;
        bus.i_branch_taken  = 1'b0;
        bus.i_branch_target = 32'd0;
        bus.i_jump_taken    = 1'b0;
        bus.i_jump_target   = 32'd0;
    endtask

    // Assert reset at a falling edge, hold across one rising edge, release at
    // the next falling edge. The following rising edge is the BOOT edge.
    task automatic do_reset();
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        #12;
        checks++; if (bus.o_pc_result !== 32'd0) begin failures++; $display("FAIL reset_pc got=%h exp=%h", bus.o_pc_result, 32'd0); end
        checks++; if (bus.o_if_id_instruction !== 32'd0) begin failures++; $display("FAIL reset_instr got=%h exp=%h", bus.o_if_id_instruction, 32'd0); end
        checks++; if (bus.o_if_id_pc_plus4 !== 32'd0) begin failures++; $display("FAIL reset_pc4 got=%h exp=%h", bus.o_if_id_pc_plus4, 32'd0); end
        checks++; if (bus.o_if_id_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.o_if_id_valid); end
        checks++; if (bus.o_halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%b exp=0", bus.o_halted); end
        checks++; if (bus.o_fetch_count !== 32'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", bus.o_fetch_count); end
    endtask

    task automatic test_boot_fetch();
        @(negedge clk);
        rst_n = 1'b1;
        step();   // BOOT edge
        checks++; if (bus.o_pc_result !== 32'd0) begin failures++; $display("FAIL boot_pc got=%h exp=%h", bus.o_pc_result, 32'd0); end
        checks++; if (bus.o_if_id_valid !== 1'b0) begin failures++; $display("FAIL boot_valid got=%b exp=0", bus.o_if_id_valid); end
        step();   // first fetch edge
        checks++; if (bus.o_if_id_instruction !== 32'd0) begin failures++; $display("FAIL fetch0_instr got=%h exp=%h", bus.o_if_id_instruction, 32'd0); end
        checks++; if (bus.o_if_id_pc_plus4 !== 32'd4) begin failures++; $display("FAIL fetch0_pc4 got=%h exp=%h", bus.o_if_id_pc_plus4, 32'd4); end
        checks++; if (bus.o_if_id_valid !== 1'b1) begin failures++; $display("FAIL fetch0_valid got=%b exp=1", bus.o_if_id_valid); end
        step();
        checks++; if (bus.o_if_id_instruction !== 32'd3) begin failures++; $display("FAIL fetch1_instr got=%h exp=%h", bus.o_if_id_instruction, 32'd3); end
        checks++; if (bus.o_if_id_pc_plus4 !== 32'd8) begin failures++; $display("FAIL fetch1_pc4 got=%h exp=%h", bus.o_if_id_pc_plus4, 32'd8); end
        checks++; if (bus.o_if_id_valid !== 1'b1) begin failures++; $display("FAIL fetch1_valid got=%b exp=1", bus.o_if_id_valid); end
        checks++; if (bus.o_fetch_count !== 32'd2) begin failures++; $display("FAIL fetch1_count got=%0d exp=2", bus.o_fetch_count); end
        checks++; if (bus.o_pc_result !== 32'd8) begin failures++; $display("FAIL fetch1_pc got=%h exp=%h", bus.o_pc_result, 32'd8); end
    endtask

    task automatic test_stall();
        bus.i_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (bus.o_pc_result !== 32'd8) begin failures++; $display("FAIL stall_pc[%0d] got=%h exp=%h", k, bus.o_pc_result, 32'd8); end
            checks++; if (bus.o_if_id_instruction !== 32'd3) begin failures++; $display("FAIL stall_instr[%0d] got=%h exp=%h", k, bus.o_if_id_instruction, 32'd3); end
            checks++; if (bus.o_if_id_pc_plus4 !== 32'd8) begin failures++; $display("FAIL stall_pc4[%0d] got=%h exp=%h", k, bus.o_if_id_pc_plus4, 32'd8); end
            checks++; if (bus.o_fetch_count !== 32'd2) begin failures++; $display("FAIL stall_count[%0d] got=%0d exp=2", k, bus.o_fetch_count); end
        end
        bus.i_stall = 1'b0;
        step();
        checks++; if (bus.o_if_id_instruction !== 32'd6) begin failures++; $display("FAIL unstall_instr got=%h exp=%h", bus.o_if_id_instruction, 32'd6); end
        checks++; if (bus.o_if_id_pc_plus4 !== 32'd12) begin failures++; $display("FAIL unstall_pc4 got=%h exp=%h", bus.o_if_id_pc_plus4, 32'd12); end
        checks++; if (bus.o_fetch_count !== 32'd3) begin failures++; $display("FAIL unstall_count got=%0d exp=3", bus.o_fetch_count); end
    endtask

    // Issue one redirect edge, then one fetch edge, checking bubble and target.
    task automatic redirect_case(input string name, input logic jmp, input logic [31:0] jt,
                                 input logic br, input logic [31:0] bt, input logic stall,
                                 input logic [31:0] exp_pc, input logic [31:0] exp_count);
        bus.i_jump_taken    = jmp;
        bus.i_jump_target   = jt;
        bus.i_branch_taken  = br;
        bus.i_branch_target = bt;
        bus.i_stall         = stall;
        step();
        clear_inputs();
        checks++; if (bus.o_pc_result !== exp_pc) begin failures++; $display("FAIL %s_pc got=%h exp=%h", name, bus.o_pc_result, exp_pc); end
        checks++; if (bus.o_if_id_valid !== 1'b0) begin failures++; $display("FAIL %s_bubble got=%b exp=0", name, bus.o_if_id_valid); end
        step();
        checks++; if (bus.o_if_id_instruction !== (exp_pc >> 2) * 3) begin failures++; $display("FAIL %s_instr got=%h exp=%h", name, bus.o_if_id_instruction, (exp_pc >> 2) * 3); end
        checks++; if (bus.o_if_id_pc_plus4 !== exp_pc + 32'd4) begin failures++; $display("FAIL %s_pc4 got=%h exp=%h", name, bus.o_if_id_pc_plus4, exp_pc + 32'd4); end
        checks++; if (bus.o_if_id_valid !== 1'b1) begin failures++; $display("FAIL %s_valid got=%b exp=1", name, bus.o_if_id_valid); end
        checks++; if (bus.o_fetch_count !== exp_count) begin failures++; $display("FAIL %s_count got=%0d exp=%0d", name, bus.o_fetch_count, exp_count); end
    endtask

    task automatic test_redirect();
        redirect_case("branch_over_stall", 1'b0, 32'd0,        1'b1, 32'h40, 1'b1, 32'h40, 32'd4);
        redirect_case("jump_over_branch",  1'b1, 32'h80,       1'b1, 32'h40, 1'b0, 32'h80, 32'd5);
        redirect_case("branch_unaligned",  1'b0, 32'd0,        1'b1, 32'h43, 1'b0, 32'h40, 32'd6);
    endtask

    task automatic test_back_to_back();
        // PC is 0x44 after the last redirect case.
        for (int k = 0; k < 4; k++) begin
            step();
            checks++; if (bus.o_if_id_instruction !== 32'((17 + k) * 3)) begin failures++; $display("FAIL b2b_instr[%0d] got=%h exp=%h", k, bus.o_if_id_instruction, 32'((17 + k) * 3)); end
            checks++; if (bus.o_if_id_pc_plus4 !== 32'(32'h48 + 4 * k)) begin failures++; $display("FAIL b2b_pc4[%0d] got=%h exp=%h", k, bus.o_if_id_pc_plus4, 32'(32'h48 + 4 * k)); end
            checks++; if (bus.o_fetch_count !== 32'(7 + k)) begin failures++; $display("FAIL b2b_count[%0d] got=%0d exp=%0d", k, bus.o_fetch_count, 7 + k); end
        end
    endtask

    task automatic test_halt();
        mem[4] = 32'hFFFF_FFFF;
        do_reset();
        step();                       // BOOT
        for (int k = 0; k < 4; k++) step();   // words 0..3
        checks++; if (bus.o_if_id_instruction !== 32'd9) begin failures++; $display("FAIL prehalt_instr got=%h exp=%h", bus.o_if_id_instruction, 32'd9); end
        checks++; if (bus.o_halted !== 1'b0) begin failures++; $display("FAIL prehalt_halted got=%b exp=0", bus.o_halted); end
        step();
        checks++; if (bus.o_halted !== 1'b1) begin failures++; $display("FAIL halt_halted got=%b exp=1", bus.o_halted); end
        checks++; if (bus.o_if_id_valid !== 1'b0) begin failures++; $display("FAIL halt_valid got=%b exp=0", bus.o_if_id_valid); end
        checks++; if (bus.o_pc_result !== 32'h10) begin failures++; $display("FAIL halt_pc got=%h exp=%h", bus.o_pc_result, 32'h10); end
        checks++; if (bus.o_fetch_count !== 32'd4) begin failures++; $display("FAIL halt_count got=%0d exp=4", bus.o_fetch_count); end
        bus.i_stall = 1'b1;           // ignored in HALT
        step();
        bus.i_stall = 1'b0;
        step();
        checks++; if (bus.o_halted !== 1'b1) begin failures++; $display("FAIL halt_hold_halted got=%b exp=1", bus.o_halted); end
        checks++; if (bus.o_pc_result !== 32'h10) begin failures++; $display("FAIL halt_hold_pc got=%h exp=%h", bus.o_pc_result, 32'h10); end
        checks++; if (bus.o_fetch_count !== 32'd4) begin failures++; $display("FAIL halt_hold_count got=%0d exp=4", bus.o_fetch_count); end
        checks++; if (bus.o_if_id_valid !== 1'b0) begin failures++; $display("FAIL halt_hold_valid got=%b exp=0", bus.o_if_id_valid); end
        bus.i_jump_taken  = 1'b1;
        bus.i_jump_target = 32'd0;
        step();
        clear_inputs();
        checks++; if (bus.o_halted !== 1'b0) begin failures++; $display("FAIL unhalt_halted got=%b exp=0", bus.o_halted); end
        checks++; if (bus.o_pc_result !== 32'd0) begin failures++; $display("FAIL unhalt_pc got=%h exp=%h", bus.o_pc_result, 32'd0); end
        checks++; if (bus.o_if_id_valid !== 1'b0) begin failures++; $display("FAIL unhalt_bubble got=%b exp=0", bus.o_if_id_valid); end
        step();
        checks++; if (bus.o_if_id_instruction !== 32'd0) begin failures++; $display("FAIL restart_instr got=%h exp=%h", bus.o_if_id_instruction, 32'd0); end
        checks++; if (bus.o_if_id_valid !== 1'b1) begin failures++; $display("FAIL restart_valid got=%b exp=1", bus.o_if_id_valid); end
        checks++; if (bus.o_fetch_count !== 32'd5) begin failures++; $display("FAIL restart_count got=%0d exp=5", bus.o_fetch_count); end
        mem[4] = 32'd12;
    endtask

    task automatic test_async_reset();
        do_reset();
        step();                            // BOOT
        for (int k = 0; k < 7; k++) step(); // PC = 0x1C
        checks++; if (bus.o_pc_result !== 32'h1C) begin failures++; $display("FAIL prereset_pc got=%h exp=%h", bus.o_pc_result, 32'h1C); end
        #2;                                // mid-cycle, no edge pending for 2 ns
        rst_n = 1'b0;
        #1;
        checks++; if (bus.o_pc_result !== 32'd0) begin failures++; $display("FAIL async_pc got=%h exp=%h", bus.o_pc_result, 32'd0); end
        checks++; if (bus.o_if_id_valid !== 1'b0) begin failures++; $display("FAIL async_valid got=%b exp=0", bus.o_if_id_valid); end
        checks++; if (bus.o_fetch_count !== 32'd0) begin failures++; $display("FAIL async_count got=%0d exp=0", bus.o_fetch_count); end
        checks++; if (bus.o_if_id_instruction !== 32'd0) begin failures++; $display("FAIL async_instr got=%h exp=%h", bus.o_if_id_instruction, 32'd0); end
    endtask

    task automatic test_wrap();
        @(negedge clk);
        wrst_n = 1'b1;
        step();   // BOOT
        checks++; if (wbus.o_pc_result !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_boot_pc got=%h exp=%h", wbus.o_pc_result, 32'hFFFF_FFFC); end
        step();
        checks++; if (wbus.o_pc_result !== 32'd0) begin failures++; $display("FAIL wrap_pc got=%h exp=%h", wbus.o_pc_result, 32'd0); end
        checks++; if (wbus.o_if_id_pc_plus4 !== 32'd0) begin failures++; $display("FAIL wrap_pc4 got=%h exp=%h", wbus.o_if_id_pc_plus4, 32'd0); end
        checks++; if (wbus.o_if_id_instruction !== 32'd189) begin failures++; $display("FAIL wrap_instr got=%h exp=%h", wbus.o_if_id_instruction, 32'd189); end
        checks++; if (wbus.o_if_id_valid !== 1'b1) begin failures++; $display("FAIL wrap_valid got=%b exp=1", wbus.o_if_id_valid); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        for (int i = 0; i < 64; i++) mem[i] = 32'(i * 3);
        wrst_n               = 1'b0;
        wbus.i_stall         = 1'b0;
        wbus.i_branch_taken  = 1'b0;
        wbus.i_branch_target = 32'd0;
        wbus.i_jump_taken    = 1'b0;
        wbus.i_jump_target   = 32'd0;

        test_reset();
        test_boot_fetch();
        test_stall();
        test_redirect();
        test_back_to_back();
        test_halt();
        test_async_reset();
        test_wrap();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
